// File: rtl/dart_pattern_seq_if.sv
// Interface bundling the dart sequencer's control, table-load and throw-output signals.
// The master side is the game controller; the slave side is the sequencer itself.
interface dart_pattern_seq_if #(
    parameter int N_PLAYERS       = 2,
    parameter int THROWS_PER_TURN = 3,
    parameter int DEPTH           = 32,
    parameter int COORD_W         = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int TW = (THROWS_PER_TURN > 1) ? $clog2(THROWS_PER_TURN) : 1;

    logic               start_i;
    logic               load_en_i;
    logic [AW-1:0]      load_addr_i;
    logic [COORD_W-1:0] load_x_i;
    logic [COORD_W-1:0] load_y_i;
    logic               load_last_i;
    logic [N_PLAYERS-1:0] player_done_i;
    logic               bust_i;
    logic               game_set_i;
    logic               dart_come_o;
    logic [COORD_W-1:0] dart_position_x_o;
    logic [COORD_W-1:0] dart_position_y_o;
    logic [PW-1:0]      player_o;
    logic [TW-1:0]      throw_idx_o;
    logic               finish_o;
    logic               timeout_o;

    modport master (
        output start_i, load_en_i, load_addr_i, load_x_i, load_y_i, load_last_i,
        output player_done_i, bust_i, game_set_i,
        input  dart_come_o, dart_position_x_o, dart_position_y_o, player_o,
        input  throw_idx_o, finish_o, timeout_o
    );

    modport slave (
        input  start_i, load_en_i, load_addr_i, load_x_i, load_y_i, load_last_i,
        input  player_done_i, bust_i, game_set_i,
        output dart_come_o, dart_position_x_o, dart_position_y_o, player_o,
        output throw_idx_o, finish_o, timeout_o
    );
endinterface

// File: rtl/dart_pattern_seq.sv
// Dart throw sequencer: replays a loaded coordinate table one throw per scored dart,
// rotating players and throw indices, with start delay, bust handling and a stall timeout.
module dart_pattern_seq #(
    parameter int N_PLAYERS       = 2,
    parameter int THROWS_PER_TURN = 3,
    parameter int DEPTH           = 32,
    parameter int COORD_W         = 8,
    parameter int START_DLY       = 10,
    parameter int TIMEOUT         = 1024
) (
    input  logic              clk,
    input  logic              reset,
    dart_pattern_seq_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
    localparam int TW  = (THROWS_PER_TURN > 1) ? $clog2(THROWS_PER_TURN) : 1;
    localparam int DW  = (START_DLY > 1) ? $clog2(START_DLY) : 1;
    localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DW-1:0]  DLY_LAST    = DW'(START_DLY - 1);
    localparam logic [TOW-1:0] TOUT_LAST   = TOW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  PLAYER_LAST = PW'(N_PLAYERS - 1);
    localparam logic [TW-1:0]  THROW_LAST  = TW'(THROWS_PER_TURN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        THROW  = 3'd2,
        FINISH = 3'd3,
        TOUT   = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      ptr_r, ptr_s, ptr_inc_s;
    logic [CW-1:0]      count_r, count_s;
    logic [PW-1:0]      player_r, player_s, player_adv_s;
    logic [TW-1:0]      throw_r, throw_s, throw_adv_s;
    logic [DW-1:0]      dly_r, dly_s;
    logic [TOW-1:0]     tout_r, tout_s;
    logic               done_prev_r;
    logic               done_edge_s;
    logic               wr_en_s;
    logic               come_r, come_s;
    logic               finish_r, finish_s;
    logic               timeout_r, timeout_s;
    logic [COORD_W-1:0] x_r, x_s, y_r, y_s;
    logic [COORD_W-1:0] mem_x_r [DEPTH];
    logic [COORD_W-1:0] mem_y_r [DEPTH];

    assign done_edge_s           = (|bus.player_done_i) & ~done_prev_r;
    assign bus.dart_come_o       = come_r;
    assign bus.dart_position_x_o = x_r;
    assign bus.dart_position_y_o = y_r;
    assign bus.player_o          = player_r;
    assign bus.throw_idx_o       = throw_r;
    assign bus.finish_o          = finish_r;
    assign bus.timeout_o         = timeout_r;

    // Throw table storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_x_r[bus.load_addr_i] <= bus.load_x_i;
            mem_y_r[bus.load_addr_i] <= bus.load_y_i;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        count_s   = count_r;
        player_s  = player_r;
        throw_s   = throw_r;
        dly_s     = dly_r;
        tout_s    = tout_r;
        come_s    = come_r;
        finish_s  = finish_r;
        timeout_s = timeout_r;
        x_s       = x_r;
        y_s       = y_r;
        wr_en_s   = 1'b0;
        ptr_inc_s = ptr_r + AW'(1);

        // A bust ends the turn no matter how many throws remain.
        if (bus.bust_i || (throw_r == THROW_LAST)) begin
            throw_adv_s  = {TW{1'b0}};
            player_adv_s = (player_r == PLAYER_LAST) ? {PW{1'b0}} : (player_r + PW'(1));
        end else begin
            throw_adv_s  = throw_r + TW'(1);
            player_adv_s = player_r;
        end

        case (state_r)
            IDLE, FINISH, TOUT: begin
                wr_en_s = bus.load_en_i;
                if (bus.load_en_i && bus.load_last_i) begin
                    count_s = {1'b0, bus.load_addr_i} + CW'(1);
                end else begin
                    count_s = count_r;
                end
                if (bus.start_i && (count_r == {CW{1'b0}})) begin
                    state_s   = FINISH;
                    come_s    = 1'b0;
                    finish_s  = 1'b1;
                    timeout_s = 1'b0;
                end else if (bus.start_i) begin
                    state_s   = DELAY;
                    ptr_s     = {AW{1'b0}};
                    player_s  = {PW{1'b0}};
                    throw_s   = {TW{1'b0}};
                    dly_s     = {DW{1'b0}};
                    come_s    = 1'b0;
                    finish_s  = 1'b0;
                    timeout_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            DELAY: begin
                if (bus.game_set_i) begin
                    state_s  = FINISH;
                    finish_s = 1'b1;
                end else if (dly_r == DLY_LAST) begin
                    state_s = THROW;
                    come_s  = 1'b1;
                    tout_s  = {TOW{1'b0}};
                    x_s     = mem_x_r[{AW{1'b0}}];
                    y_s     = mem_y_r[{AW{1'b0}}];
                end else begin
                    dly_s = dly_r + DW'(1);
                end
            end
            THROW: begin
                if (bus.game_set_i) begin
                    state_s  = FINISH;
                    come_s   = 1'b0;
                    finish_s = 1'b1;
                end else if (done_edge_s) begin
                    tout_s   = {TOW{1'b0}};
                    player_s = player_adv_s;
                    throw_s  = throw_adv_s;
                    if ({1'b0, ptr_r} == (count_r - CW'(1))) begin
                        state_s  = FINISH;
                        come_s   = 1'b0;
                        finish_s = 1'b1;
                    end else begin
                        ptr_s = ptr_inc_s;
                        x_s   = mem_x_r[ptr_inc_s];
                        y_s   = mem_y_r[ptr_inc_s];
                    end
                end else if (tout_r == TOUT_LAST) begin
                    state_s   = TOUT;
                    come_s    = 1'b0;
                    timeout_s = 1'b1;
                end else begin
                    tout_s = tout_r + TOW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            ptr_r       <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            player_r    <= {PW{1'b0}};
            throw_r     <= {TW{1'b0}};
            dly_r       <= {DW{1'b0}};
            tout_r      <= {TOW{1'b0}};
            done_prev_r <= 1'b0;
            come_r      <= 1'b0;
            finish_r    <= 1'b0;
            timeout_r   <= 1'b0;
            x_r         <= {COORD_W{1'b0}};
            y_r         <= {COORD_W{1'b0}};
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            count_r     <= count_s;
            player_r    <= player_s;
            throw_r     <= throw_s;
            dly_r       <= dly_s;
            tout_r      <= tout_s;
            done_prev_r <= |bus.player_done_i;
            come_r      <= come_s;
            finish_r    <= finish_s;
            timeout_r   <= timeout_s;
            x_r         <= x_s;
            y_r         <= y_s;
        end
    end
endmodule

// File: tb/tb_dart_pattern_seq.sv
// Self-checking bench for dart_pattern_seq: a cycle-stepped behavioural model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_dart_pattern_seq;
    localparam int N_PLAYERS       = 2;
    localparam int THROWS_PER_TURN = 3;
    localparam int DEPTH           = 32;
    localparam int COORD_W         = 8;
    localparam int START_DLY       = 10;
    localparam int TIMEOUT         = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    dart_pattern_seq_if #(
        .N_PLAYERS(N_PLAYERS), .THROWS_PER_TURN(THROWS_PER_TURN),
        .DEPTH(DEPTH), .COORD_W(COORD_W)
    ) bus ();

    dart_pattern_seq #(
        .N_PLAYERS(N_PLAYERS), .THROWS_PER_TURN(THROWS_PER_TURN), .DEPTH(DEPTH),
        .COORD_W(COORD_W), .START_DLY(START_DLY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 waiting, 2 throwing, 3 finished, 4 timed out.
    int m_mode = 0, m_wait = 0, m_quiet = 0, m_seq = 0, m_count = 0, m_pl = 0, m_th = 0;
    int m_tx [DEPTH];
    int m_ty [DEPTH];
    bit m_prev = 1'b0;
    bit e_come = 1'b0, e_fin = 1'b0, e_to = 1'b0;
    int e_x = 0, e_y = 0;

    task automatic end_turn_or_next();
        if (bus.bust_i || m_th == THROWS_PER_TURN - 1) begin
            m_th = 0;
            m_pl = (m_pl + 1) % N_PLAYERS;
        end else begin
            m_th = m_th + 1;
        end
    endtask

    task automatic model_step();
        bit any, edge_seen, quiet_mode;
        any        = |bus.player_done_i;
        edge_seen  = any && !m_prev;
        m_prev     = any;
        quiet_mode = (m_mode == 0 || m_mode == 3 || m_mode == 4);
        if (reset) begin
            m_mode = 0; m_count = 0; m_seq = 0; m_pl = 0; m_th = 0; m_prev = 1'b0;
            e_come = 1'b0; e_fin = 1'b0; e_to = 1'b0; e_x = 0; e_y = 0;
        end else begin
            if (quiet_mode && bus.start_i) begin
                if (m_count == 0) begin
                    m_mode = 3; e_fin = 1'b1; e_to = 1'b0; e_come = 1'b0;
                end else begin
                    m_mode = 1; m_wait = START_DLY; m_seq = 0; m_pl = 0; m_th = 0;
                    e_fin = 1'b0; e_to = 1'b0; e_come = 1'b0;
                end
            end else if (m_mode == 1) begin
                if (bus.game_set_i) begin
                    m_mode = 3; e_fin = 1'b1;
                end else begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) begin
                        m_mode = 2; m_quiet = 0; e_come = 1'b1;
                        e_x = m_tx[0]; e_y = m_ty[0];
                    end
                end
            end else if (m_mode == 2) begin
                if (bus.game_set_i) begin
                    m_mode = 3; e_fin = 1'b1; e_come = 1'b0;
                end else if (edge_seen) begin
                    m_quiet = 0;
                    end_turn_or_next();
                    if (m_seq == m_count - 1) begin
                        m_mode = 3; e_fin = 1'b1; e_come = 1'b0;
                    end else begin
                        m_seq = m_seq + 1;
                        e_x = m_tx[m_seq]; e_y = m_ty[m_seq];
                    end
                end else begin
                    m_quiet = m_quiet + 1;
                    if (m_quiet == TIMEOUT) begin
                        m_mode = 4; e_to = 1'b1; e_come = 1'b0;
                    end
                end
            end
            if (quiet_mode && bus.load_en_i) begin
                m_tx[bus.load_addr_i] = int'(bus.load_x_i);
                m_ty[bus.load_addr_i] = int'(bus.load_y_i);
                if (bus.load_last_i) m_count = int'(bus.load_addr_i) + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_tests++;
                if (bus.dart_come_o !== e_come || bus.finish_o !== e_fin || bus.timeout_o !== e_to ||
                    bus.dart_position_x_o !== COORD_W'(e_x) || bus.dart_position_y_o !== COORD_W'(e_y) ||
                    int'(bus.player_o) != m_pl || int'(bus.throw_idx_o) != m_th) begin
                    n_fail++;
                    $display("FAIL cycle_cmp t=%0t got/exp come=%0b/%0b fin=%0b/%0b to=%0b/%0b x=%0d/%0d y=%0d/%0d pl=%0d/%0d th=%0d/%0d",
                             $time, bus.dart_come_o, e_come, bus.finish_o, e_fin, bus.timeout_o, e_to,
                             bus.dart_position_x_o, e_x, bus.dart_position_y_o, e_y,
                             bus.player_o, m_pl, bus.throw_idx_o, m_th);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a, input int x, input int y, input bit last);
        @(negedge clk);
        bus.load_en_i = 1'b1; bus.load_addr_i = 5'(a);
        bus.load_x_i = 8'(x); bus.load_y_i = 8'(y); bus.load_last_i = last;
        @(negedge clk);
        bus.load_en_i = 1'b0; bus.load_last_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); bus.start_i = 1'b1;
        @(negedge clk); bus.start_i = 1'b0;
    endtask

    task automatic pulse_done(input logic [1:0] mask, input bit b);
        @(negedge clk); bus.player_done_i = mask; bus.bust_i = b;
        @(negedge clk); bus.player_done_i = 2'b00; bus.bust_i = 1'b0;
    endtask

    task automatic pulse_game_set();
        @(negedge clk); bus.game_set_i = 1'b1;
        @(negedge clk); bus.game_set_i = 1'b0;
    endtask

    // Returns the number of clock edges seen until dart_come_o rises (bounded).
    task automatic wait_come(output int lat);
        lat = 0;
        while (bus.dart_come_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int pl_seen [7];
    int th_seen [7];
    int exp_pl  [7] = '{0, 0, 0, 1, 1, 1, 0};
    int exp_th  [7] = '{0, 1, 2, 0, 1, 2, 0};

    initial begin
        bus.start_i = 1'b0; bus.load_en_i = 1'b0; bus.load_addr_i = 5'd0;
        bus.load_x_i = 8'd0; bus.load_y_i = 8'd0; bus.load_last_i = 1'b0;
        bus.player_done_i = 2'b00; bus.bust_i = 1'b0; bus.game_set_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_tx[i] = 0; m_ty[i] = 0; end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_come", int'(bus.dart_come_o), 0);
        check("reset_finish", int'(bus.finish_o), 0);
        check("reset_timeout", int'(bus.timeout_o), 0);

        // Three-entry table: ordered replay, start latency and finish.
        load(0, 13, 2, 1'b0); load(1, 14, 2, 1'b0); load(2, 14, 3, 1'b1);
        pulse_start();
        wait_come(lat);
        check("start_latency", lat, START_DLY);
        check("t1_x0", int'(bus.dart_position_x_o), 13);
        check("t1_y0", int'(bus.dart_position_y_o), 2);
        pulse_done(2'b01, 1'b0);
        check("t1_x1", int'(bus.dart_position_x_o), 14);
        check("t1_y1", int'(bus.dart_position_y_o), 2);
        pulse_done(2'b01, 1'b0);
        check("t1_y2", int'(bus.dart_position_y_o), 3);
        pulse_done(2'b01, 1'b0);
        check("t1_finish", int'(bus.finish_o), 1);
        check("t1_come_low", int'(bus.dart_come_o), 0);

        // Seven entries: player/throw rotation without busts.
        for (int i = 0; i < 7; i++) load(i, i * 3 + 1, 20 + i, i == 6);
        pulse_start();
        wait_come(lat);
        for (int k = 0; k < 7; k++) begin
            pl_seen[k] = int'(bus.player_o);
            th_seen[k] = int'(bus.throw_idx_o);
            pulse_done((k % 2 == 0) ? 2'b01 : 2'b10, 1'b0);
        end
        for (int k = 0; k < 7; k++) begin
            check($sformatf("rot_player%0d", k), pl_seen[k], exp_pl[k]);
            check($sformatf("rot_throw%0d", k), th_seen[k], exp_th[k]);
        end
        check("t2_finish", int'(bus.finish_o), 1);

        // Bust on first throw; a write during the delay must be ignored.
        pulse_start();
        load(0, 99, 99, 1'b1);
        wait_come(lat);
        check("ignored_write_x", int'(bus.dart_position_x_o), 1);
        pulse_done(2'b01, 1'b1);
        check("bust_player", int'(bus.player_o), 1);
        check("bust_throw", int'(bus.throw_idx_o), 0);
        pulse_game_set();
        check("gs_finish", int'(bus.finish_o), 1);

        // game_set together with a done edge at ptr=1.
        pulse_start();
        wait_come(lat);
        pulse_done(2'b01, 1'b0);
        @(negedge clk); bus.player_done_i = 2'b10; bus.game_set_i = 1'b1;
        @(negedge clk); bus.player_done_i = 2'b00; bus.game_set_i = 1'b0;
        check("gs_prio_finish", int'(bus.finish_o), 1);
        check("gs_prio_x", int'(bus.dart_position_x_o), 4);
        check("gs_prio_y", int'(bus.dart_position_y_o), 21);

        // Timeout, then restart from entry 0 with done held high across entry.
        pulse_start();
        wait_come(lat);
        lat = 0;
        while (bus.timeout_o !== 1'b1 && lat < TIMEOUT + 50) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_latency", lat, TIMEOUT);
        check("timeout_come", int'(bus.dart_come_o), 0);
        @(negedge clk); bus.player_done_i = 2'b01;
        pulse_start();
        wait_come(lat);
        check("restart_timeout_clr", int'(bus.timeout_o), 0);
        check("restart_x", int'(bus.dart_position_x_o), 1);
        pulse_start();
        check("start_ignored_x", int'(bus.dart_position_x_o), 1);
        @(negedge clk); bus.player_done_i = 2'b00;
        @(negedge clk);
        check("held_level_x", int'(bus.dart_position_x_o), 1);
        pulse_done(2'b01, 1'b0);
        check("after_release_x", int'(bus.dart_position_x_o), 4);
        pulse_game_set();

        // Reset mid-throw at ptr=4, then start with an empty table.
        pulse_start();
        wait_come(lat);
        for (int k = 0; k < 4; k++) pulse_done(2'b01, 1'b0);
        check("ptr4_x", int'(bus.dart_position_x_o), 13);
        check("ptr4_y", int'(bus.dart_position_y_o), 24);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("rst_come", int'(bus.dart_come_o), 0);
        check("rst_x", int'(bus.dart_position_x_o), 0);
        check("rst_player", int'(bus.player_o), 0);
        check("rst_throw", int'(bus.throw_idx_o), 0);
        pulse_start();
        check("empty_finish", int'(bus.finish_o), 1);
        check("empty_come", int'(bus.dart_come_o), 0);
        repeat (15) @(negedge clk);
        check("empty_no_throw", int'(bus.dart_come_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
